// File: rtl/ssram_ctrl_if.sv
// ----------------------------------------------------------------------------
// ssram_ctrl_if
// Bus-side handshake between the peripheral interconnect (master) and the
// ssram controller (slave). Single-beat req/gnt/rvalid transactions.
//   req_i    master->slave  transaction request
//   we_i     master->slave  1=write, 0=read
//   addr_i   master->slave  word address
//   wdata_i  master->slave  write data
//   gnt_o    slave->master  request accepted (combinational)
//   rvalid_o slave->master  one-cycle response pulse
//   rdata_o  slave->master  read data, valid with rvalid_o
//   err_o    slave->master  read ended with FLAG still set, valid with rvalid_o
// ----------------------------------------------------------------------------
interface ssram_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              gnt_o;
    logic              rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/ssram_ctrl.sv
// ----------------------------------------------------------------------------
// ssram_ctrl
// Initiator for one ssram macro. Converts single-beat bus transactions into
// macro pin sequences (CEN/WEN/BRS/EN/MODE/D), samples Q/FLAG after RD_WAIT
// cycles of CEN low, and retries a read up to MAX_RETRY times while FLAG=1.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus               ssram_ctrl_if slave side (req/we/addr/wdata/gnt/
//                     rvalid/rdata/err)
//   busy_o            FSM not in IDLE
//   cfg_en_i/mode_i   EN/MODE values, latched at grant
//   sram_*_o          macro pins (CEN active-low, WEN 0=write)
//   sram_q_i/flag_i   macro read data and retry flag
// ----------------------------------------------------------------------------
module ssram_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int RD_WAIT   = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    ssram_ctrl_if.slave       bus,
    input  logic [11:0]       cfg_en_i,
    input  logic              cfg_mode_i,
    output logic              busy_o,
    output logic              sram_cen_o,
    output logic              sram_wen_o,
    output logic [ADDR_W-1:0] sram_brs_o,
    output logic [11:0]       sram_en_o,
    output logic              sram_mode_o,
    output logic [DATA_W-1:0] sram_d_o,
    input  logic [DATA_W-1:0] sram_q_i,
    input  logic              sram_flag_i
);
    localparam logic [4:0] WAIT_LOAD = 5'(RD_WAIT - 1);
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RECOV,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        wait_q, wait_d;
    logic [2:0]        retry_q, retry_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [11:0]       en_q, en_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              grant;

    // Grant is suppressed during reset so nothing is accepted while the
    // state register is being forced back to IDLE.
    assign grant     = bus.req_i & (state_q == S_IDLE) & ~rst;
    assign bus.gnt_o = grant;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        retry_d = retry_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        en_d    = en_q;
        mode_d  = mode_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    addr_d  = bus.addr_i;
                    wdata_d = bus.wdata_i;
                    en_d    = cfg_en_i;
                    mode_d  = cfg_mode_i;
                    if (bus.we_i) begin
                        err_d   = 1'b0;
                        state_d = S_WRITE;
                    end else begin
                        wait_d  = WAIT_LOAD;
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: state_d = S_RESP;
            S_READ: begin
                if (wait_q == 5'd0) begin
                    if (!sram_flag_i) begin
                        rdata_d = sram_q_i;
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 3'd1;
                        state_d = S_RECOV;
                    end else begin
                        // Out of retries: hand back whatever Q holds, flagged.
                        rdata_d = sram_q_i;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end else begin
                    wait_d = wait_q - 5'd1;
                end
            end
            // One cycle with CEN high lets the macro's own FSM return to idle
            // before the next attempt.
            S_RECOV: begin
                wait_d  = WAIT_LOAD;
                state_d = S_READ;
            end
            S_RESP: begin
                retry_d = 3'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            retry_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            en_q    <= '0;
            mode_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            retry_q <= retry_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Pins are decoded from registered state only, so they change on clock
    // edges and return to idle values one edge after rst.
    assign sram_cen_o   = ~((state_q == S_WRITE) | (state_q == S_READ));
    assign sram_wen_o   = ~(state_q == S_WRITE);
    assign sram_brs_o   = addr_q;
    assign sram_d_o     = wdata_q;
    assign sram_en_o    = en_q;
    assign sram_mode_o  = mode_q;
    assign busy_o       = (state_q != S_IDLE);
    assign bus.rvalid_o = (state_q == S_RESP);
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;
endmodule

// File: tb/tb_ssram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ssram_ctrl
// Self-checking bench for ssram_ctrl. A behavioural macro model answers the
// controller's pins (memory array, per-attempt FLAG schedule, Q offset by the
// attempt number). Expected latency/rdata/err come from a transaction-level
// model: retries = index of first clear FLAG bit, latency from that count.
// ----------------------------------------------------------------------------
module tb_ssram_ctrl;
    localparam int AW        = 8;
    localparam int DW        = 32;
    localparam int RD_WAIT   = 8;
    localparam int MAX_RETRY = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [11:0]   cfg_en;
    logic          cfg_mode;
    logic          busy, cen, wen, mode, flag;
    logic [AW-1:0] brs;
    logic [11:0]   en;
    logic [DW-1:0] d, q;

    always #5 clk = ~clk;

    ssram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ssram_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RD_WAIT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cfg_en_i(cfg_en), .cfg_mode_i(cfg_mode), .busy_o(busy),
        .sram_cen_o(cen), .sram_wen_o(wen), .sram_brs_o(brs),
        .sram_en_o(en), .sram_mode_o(mode), .sram_d_o(d),
        .sram_q_i(q), .sram_flag_i(flag)
    );

    // ---------------- macro model ----------------
    logic [DW-1:0] mac_mem [256];
    int            attempt;
    logic [7:0]    flag_mask;

    assign q    = mac_mem[brs] + DW'(attempt);
    assign flag = flag_mask[attempt[2:0]];

    always @(posedge clk) begin
        if (rst || bus.gnt_o) attempt <= 0;
        else if (cen && busy && !bus.rvalid_o) attempt <= attempt + 1;
        if (!rst && cen === 1'b0 && wen === 1'b0) mac_mem[brs] <= d;
    end

    // ---------------- reference state ----------------
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] ref_rdata;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction through the bus, checked against the model.
    task automatic do_txn(input string tag, input logic we, input logic [7:0] a,
                          input logic [31:0] wd, input logic [7:0] mask,
                          input logic [11:0] e, input logic m);
        int         k, lat, cyc, cen_low, recov;
        logic [31:0] exp_rd;
        logic       exp_err, pins_ok, seen;
        if (we) begin
            k = 0; lat = 2; exp_rd = ref_rdata; exp_err = 1'b0;
            ref_mem[a] = wd;
        end else begin
            k = 0;
            while (k < MAX_RETRY && mask[k]) k++;
            exp_err   = mask[k];
            lat       = (k + 1) * (RD_WAIT + 1);
            exp_rd    = ref_mem[a] + 32'(k);
            ref_rdata = exp_rd;
        end
        @(negedge clk);
        flag_mask = mask;
        bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = a; bus.wdata_i = wd;
        cfg_en = e; cfg_mode = m;
        #1 check({tag, "_gnt"}, 64'(bus.gnt_o), 64'd1);
        @(negedge clk);
        // Scramble everything after grant; the latched copies must hold.
        bus.req_i = 1'b0; bus.addr_i = ~a; bus.wdata_i = ~wd;
        bus.we_i = ~we; cfg_en = ~e; cfg_mode = ~m;
        cyc = 1; cen_low = 0; recov = 0; pins_ok = 1'b1; seen = 1'b0;
        while (cyc < 100) begin
            if (cen === 1'b0) cen_low++;
            if (cen === 1'b1 && busy === 1'b1 && bus.rvalid_o === 1'b0) recov++;
            if (en !== e || mode !== m || brs !== a) pins_ok = 1'b0;
            if (we && cyc == 1) begin
                check({tag, "_wr_cen"}, 64'(cen), 64'd0);
                check({tag, "_wr_wen"}, 64'(wen), 64'd0);
                check({tag, "_wr_d"}, 64'(d), 64'(wd));
            end
            if (bus.rvalid_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_rvalid_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_rdata"}, 64'(bus.rdata_o), 64'(exp_rd));
        check({tag, "_err"}, 64'(bus.err_o), 64'(exp_err));
        check({tag, "_cen_low"}, 64'(cen_low), we ? 64'd1 : 64'((k + 1) * RD_WAIT));
        check({tag, "_recov"}, 64'(recov), 64'(k));
        check({tag, "_pins_held"}, 64'(pins_ok), 64'd1);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) begin
            mac_mem[i] = '0;
            ref_mem[i] = '0;
        end
        ref_rdata = '0;
        flag_mask = '0;
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 8'h33; bus.wdata_i = '1;
        cfg_en = 12'hfff; cfg_mode = 1'b1;

        // Reset values (req held high: no grant while in reset).
        repeat (2) @(negedge clk);
        check("rst_cen", 64'(cen), 64'd1);
        check("rst_wen", 64'(wen), 64'd1);
        check("rst_brs", 64'(brs), 64'd0);
        check("rst_d", 64'(d), 64'd0);
        check("rst_en", 64'(en), 64'd0);
        check("rst_mode", 64'(mode), 64'd0);
        check("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
        check("rst_rdata", 64'(bus.rdata_o), 64'd0);
        check("rst_err", 64'(bus.err_o), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_gnt", 64'(bus.gnt_o), 64'd0);
        bus.req_i = 1'b0;
        rst = 1'b0;

        // 1: write then read back, no flag.
        do_txn("wr05", 1'b1, 8'h05, 32'hDEADBEEF, 8'h00, 12'h001, 1'b0);
        do_txn("rd05", 1'b0, 8'h05, 32'h0, 8'h00, 12'h001, 1'b0);
        // 2: one retry, rdata is the second Q.
        do_txn("wr10", 1'b1, 8'h10, 32'h12345678, 8'h00, 12'h002, 1'b0);
        do_txn("rd10_retry", 1'b0, 8'h10, 32'h0, 8'h01, 12'h002, 1'b0);
        // 3: flag stuck, err after MAX_RETRY retries.
        do_txn("rd_stuck", 1'b0, 8'h10, 32'h0, 8'hff, 12'h003, 1'b0);
        // 6: EN/MODE latched at grant, held through the read.
        do_txn("cfg_hold", 1'b0, 8'h05, 32'h0, 8'h00, 12'h004, 1'b1);

        // 4: reset in cycle T+4 of a read.
        @(negedge clk);
        flag_mask = 8'h00;
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 8'h20;
        #1 check("rstmid_gnt", 64'(bus.gnt_o), 64'd1);
        @(negedge clk);
        bus.req_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_cen", 64'(cen), 64'd1);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_rvalid", 64'(bus.rvalid_o), 64'd0);
        ref_rdata = '0;
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 8'h21; bus.wdata_i = 32'hA5A5_0001;
        #1 check("rstmid_gnt_in_rst", 64'(bus.gnt_o), 64'd0);
        rst = 1'b0;
        #1 check("rstmid_gnt_after", 64'(bus.gnt_o), 64'd1);
        ref_mem[8'h21] = 32'hA5A5_0001;
        @(negedge clk);
        bus.req_i = 1'b0;
        cyc = 1;
        while (bus.rvalid_o !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rstmid_wr_latency", 64'(cyc), 64'd2);
        check("rstmid_rdata_cleared", 64'(bus.rdata_o), 64'd0);

        // 5: back-to-back writes with req held high.
        @(negedge clk);
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 8'h01; bus.wdata_i = 32'h1111_0001;
        #1 check("b2b_gnt_T", 64'(bus.gnt_o), 64'd1);
        @(negedge clk);
        bus.addr_i = 8'h02; bus.wdata_i = 32'h2222_0002;
        #1 check("b2b_gnt_T1", 64'(bus.gnt_o), 64'd0);
        check("b2b_brs_T1", 64'(brs), 64'h01);
        check("b2b_d_T1", 64'(d), 64'h1111_0001);
        @(negedge clk);
        check("b2b_gnt_T2", 64'(bus.gnt_o), 64'd0);
        check("b2b_rvalid_T2", 64'(bus.rvalid_o), 64'd1);
        @(negedge clk);
        check("b2b_gnt_T3", 64'(bus.gnt_o), 64'd1);
        @(negedge clk);
        bus.req_i = 1'b0;
        check("b2b_brs_2", 64'(brs), 64'h02);
        check("b2b_cen_2", 64'(cen), 64'd0);
        @(negedge clk);
        check("b2b_rvalid_2", 64'(bus.rvalid_o), 64'd1);
        ref_mem[8'h01] = 32'h1111_0001;
        ref_mem[8'h02] = 32'h2222_0002;
        do_txn("rd01", 1'b0, 8'h01, 32'h0, 8'h00, 12'h005, 1'b0);
        do_txn("rd02", 1'b0, 8'h02, 32'h0, 8'h00, 12'h006, 1'b0);

        // Randomised traffic over a small address window.
        for (int n = 0; n < 25; n++) begin
            logic        rwe;
            logic [7:0]  ra, rm;
            logic [31:0] rwd;
            rwe = 1'($urandom_range(0, 1));
            ra  = 8'($urandom_range(0, 7));
            rm  = 8'($urandom_range(0, 15));
            rwd = $urandom;
            do_txn("rand", rwe, ra, rwd, rm, 12'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ssram_ctrl.md
Name: ssram_ctrl

Overview:
- Bus-side initiator that drives one ssram macro.
- Turns single-beat req/gnt/rvalid transactions (32-bit, 8-bit word address) into macro pin sequences on CEN, WEN, BRS, EN, MODE and D.
- Captures Q and FLAG from the macro. When FLAG is set, the read is retried automatically.
- Sits between the peripheral interconnect and the ssram instance.

Parameters:
- ADDR_W, 8: word address width; drives BRS.
- DATA_W, 32: data width.
- RD_WAIT, 8: cycles CEN is held low per read attempt before Q/FLAG are sampled. Range 1..31.
- MAX_RETRY, 3: retries after the first attempt when FLAG=1. Range 0..7.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_i  in  1  transaction request
- we_i  in  1  1=write, 0=read
- addr_i  in  ADDR_W  word address
- wdata_i  in  DATA_W  write data
- gnt_o  out  1  request accepted
- rvalid_o  out  1  one-cycle response pulse (reads and writes)
- rdata_o  out  DATA_W  read data, valid when rvalid_o=1
- err_o  out  1  read finished with FLAG still set, qualified by rvalid_o
- busy_o  out  1  FSM not in IDLE
- cfg_en_i  in  12  EN value for the macro
- cfg_mode_i  in  1  MODE value for the macro
- sram_cen_o  out  1  macro CEN, active-low
- sram_wen_o  out  1  macro WEN, 0=write
- sram_brs_o  out  ADDR_W  macro BRS
- sram_en_o  out  12  macro EN
- sram_mode_o  out  1  macro MODE
- sram_d_o  out  DATA_W  macro D
- sram_q_i  in  DATA_W  macro Q
- sram_flag_i  in  1  macro FLAG

Behaviour:
- Clocking/reset: single clock; rst is synchronous and active-high; all state is registered on clk.
- Values while rst=1: sram_cen_o=1, sram_wen_o=1, sram_brs_o=0, sram_d_o=0, sram_en_o=0, sram_mode_o=0, rvalid_o=0, rdata_o=0, err_o=0, busy_o=0. State=IDLE; retry counter and wait counter are 0.
- gnt_o is combinational: gnt_o = req_i & (state==IDLE). In reset, gnt_o=0.
- Grant latch: at the grant edge, addr_i, wdata_i, we_i, cfg_en_i and cfg_mode_i are latched. Inputs are ignored after grant until the next IDLE.
- States and transitions:
  - IDLE: CEN=1, WEN=1. On grant with we_i=1, go to WRITE. On grant with we_i=0, go to READ and load wait_cnt=RD_WAIT-1.
  - WRITE (1 cycle): CEN=0, WEN=0, BRS and D driven from the latched values. Next state is RESP.
  - READ: CEN=0, WEN=1, BRS/EN/MODE driven from the latched values. wait_cnt decrements each cycle. When wait_cnt==0, sram_q_i and sram_flag_i are sampled:
    - flag=0: rdata←Q, err←0, go to RESP.
    - flag=1 and retry_cnt<MAX_RETRY: retry_cnt++, go to RECOV.
    - flag=1 and retry_cnt==MAX_RETRY: rdata←Q, err←1, go to RESP.
  - RECOV (1 cycle): CEN=1 so the macro FSM returns to idle. Reload wait_cnt=RD_WAIT-1 and go to READ.
  - RESP (1 cycle): rvalid_o=1, rdata_o and err_o stable. Clear retry_cnt and go to IDLE. For writes, rdata_o holds its previous value and err_o=0.
- Latency (T = grant cycle):
  - Write: CEN low during T+1; rvalid_o at T+2.
  - Read with k retries: rvalid_o at T+(k+1)·(RD_WAIT+1).
  - Minimum spacing between grants: 3 cycles for writes, RD_WAIT+2 for reads.
- No grant is issued outside IDLE. A req_i held through busy is granted in the first IDLE cycle.
- MODE=1 is passed through unchanged. The controller never suppresses a retry based on MODE.
- Reset mid-operation: on the next edge the macro lines return to their reset values (CEN=1), rvalid_o stays 0 and the transaction is dropped.
- rdata_o holds its last read value until the next read response.

Test Plan:
1. Write 0xDEADBEEF to addr 0x05, then read 0x05, with FLAG tied 0 and RD_WAIT=8.
   - Write: rvalid at T+2 with CEN=0/WEN=0/BRS=0x05/D=0xDEADBEEF during T+1.
   - Read: rvalid at T+9 with rdata=0xDEADBEEF and err=0.
2. Read addr 0x10, with FLAG=1 on the first sample and 0 on the second.
   - Exactly one RECOV cycle with CEN=1.
   - rvalid at T+18, err=0, rdata = second Q.
3. Read with FLAG stuck at 1 and MAX_RETRY=3.
   - 4 CEN-low windows of 8 cycles each, 3 RECOV cycles.
   - rvalid at T+36, err=1.
4. Assert rst during cycle T+4 of a read.
   - CEN=1 and busy=0 on the next edge.
   - No rvalid.
   - A new req is granted in the first cycle after rst is released.
5. Hold req_i=1 for back-to-back writes to 0x01 and 0x02.
   - gnt only at T and T+3.
   - Second BRS=0x02.
   - Changing addr_i during T+1..T+2 has no effect on BRS.
6. Set cfg_en_i=0x004 and cfg_mode_i=1 at grant, then change them during the read.
   - sram_en_o stays 0x004 and sram_mode_o stays 1 until RESP.
